// File: rtl/controle_ula_if.sv
`default_nettype none
// ============================================================================
//  Module   : controle_ula_if
//  Brief    : Instruction/load handshake and ULA operand/result bundle for
//             the controle_ula sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface controle_ula_if #(
    parameter int LARGURA = 8
);
    logic [7:0]         instrucao;
    logic               valido;
    logic               pronto;
    logic               carga_en;
    logic [1:0]         carga_end;
    logic [LARGURA-1:0] carga_dado;
    logic [LARGURA-1:0] Entrada1;
    logic [LARGURA-1:0] Entrada2;
    logic [1:0]         ALUOp;
    logic [LARGURA-1:0] Resultado;
    logic               Zero;
    logic               concluido;
    logic               flag_zero;
    logic [LARGURA-1:0] resultado_out;

    // Sequencer side: drives the ULA operands and reports completion.
    modport master (
        input  instrucao, valido, carga_en, carga_end, carga_dado,
        input  Resultado, Zero,
        output pronto, Entrada1, Entrada2, ALUOp,
        output concluido, flag_zero, resultado_out
    );

    // Environment side: instruction fetch, load source and the ULA itself.
    modport slave (
        output instrucao, valido, carga_en, carga_end, carga_dado,
        output Resultado, Zero,
        input  pronto, Entrada1, Entrada2, ALUOp,
        input  concluido, flag_zero, resultado_out
    );
endinterface
`default_nettype wire

// File: rtl/controle_ula.sv
`default_nettype none
// ============================================================================
//  Module   : controle_ula
//  Brief    : Four-phase sequencer feeding the combinational ULA from a small
//             register bank and writing results back.
//  Revision : 1.0  initial release
// ============================================================================
module controle_ula #(
    parameter int LARGURA  = 8,
    parameter int NUM_REGS = 4
) (
    input  wire logic          clock,
    input  wire logic          reset,
    controle_ula_if.master     bus
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        LEITURA  = 2'd1,
        EXECUCAO = 2'd2,
        ESCRITA  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [LARGURA-1:0] r_banco [NUM_REGS];
    logic [1:0]         r_op;
    logic [1:0]         r_rd;
    logic [1:0]         r_rs;
    logic [1:0]         r_rt;
    logic [LARGURA-1:0] r_entrada1;
    logic [LARGURA-1:0] r_entrada2;
    logic [1:0]         r_aluop;
    logic [LARGURA-1:0] r_res;
    logic               r_zero;
    logic [LARGURA-1:0] r_resultado_out;
    logic               r_flag_zero;

    always_comb begin
        w_next = OCIOSO;
        case (r_state)
            OCIOSO:   w_next = bus.valido ? LEITURA : OCIOSO;
            LEITURA:  w_next = EXECUCAO;
            EXECUCAO: w_next = ESCRITA;
            ESCRITA:  w_next = OCIOSO;
            default:  w_next = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= OCIOSO;
            r_op            <= '0;
            r_rd            <= '0;
            r_rs            <= '0;
            r_rt            <= '0;
            r_entrada1      <= '0;
            r_entrada2      <= '0;
            r_aluop         <= '0;
            r_res           <= '0;
            r_zero          <= 1'b0;
            r_resultado_out <= '0;
            r_flag_zero     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_banco[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            case (r_state)
                OCIOSO: begin
                    // Load and accept may share this edge; the load lands
                    // first, so the following operand read sees it.
                    if (bus.carga_en) begin
                        r_banco[bus.carga_end] <= bus.carga_dado;
                    end
                    if (bus.valido) begin
                        r_op <= bus.instrucao[7:6];
                        r_rd <= bus.instrucao[5:4];
                        r_rs <= bus.instrucao[3:2];
                        r_rt <= bus.instrucao[1:0];
                    end
                end
                LEITURA: begin
                    r_entrada1 <= r_banco[r_rs];
                    r_entrada2 <= r_banco[r_rt];
                    r_aluop    <= r_op;
                end
                EXECUCAO: begin
                    r_res  <= bus.Resultado;
                    r_zero <= bus.Zero;
                end
                ESCRITA: begin
                    r_banco[r_rd]   <= r_res;
                    r_resultado_out <= r_res;
                    r_flag_zero     <= r_zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.pronto        = (r_state == OCIOSO) && !reset;
    assign bus.concluido     = (r_state == ESCRITA);
    assign bus.Entrada1      = r_entrada1;
    assign bus.Entrada2      = r_entrada2;
    assign bus.ALUOp         = r_aluop;
    assign bus.resultado_out = r_resultado_out;
    assign bus.flag_zero     = r_flag_zero;

endmodule
`default_nettype wire

// File: doc/controle_ula.md
Name: controle_ula

Overview:
- Multi-cycle sequencer that issues work to the 8-bit ULA and collects its results; it is the initiator of the ULA operand/opcode interface.
- Owns a small register bank and accepts 8-bit instructions over a valido/pronto handshake.
- Drives Entrada1, Entrada2 and ALUOp to the ULA, samples Resultado and Zero, and writes the result back to the bank.
- Sits between instruction fetch and the ULA in the 8-bit datapath.

Parameters:
- LARGURA, 8, data width of registers and ULA operands.
- NUM_REGS, 4, register bank depth; fixed to 4 by the 2-bit register fields.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- instrucao  input  8  [7:6] op, [5:4] rd, [3:2] rs, [1:0] rt.
- valido  input  1  instrucao valid.
- pronto  output  1  block can accept an instruction.
- carga_en  input  1  direct register load request.
- carga_end  input  2  load target register.
- carga_dado  input  8  load value.
- Entrada1  output  8  ULA operand 1 (registered).
- Entrada2  output  8  ULA operand 2 (registered).
- ALUOp  output  2  ULA operation (registered).
- Resultado  input  8  ULA result.
- Zero  input  1  ULA zero flag (1 when Resultado == 0).
- concluido  output  1  one-cycle pulse on writeback.
- flag_zero  output  1  Zero captured from the last completed instruction.
- resultado_out  output  8  last written-back value.

Behaviour:
- Reset (synchronous, active-high) clears all registers, Entrada1, Entrada2, ALUOp, concluido, flag_zero and resultado_out to 0, and sets state = OCIOSO.
- pronto = 1 combinationally in OCIOSO when reset is low; pronto = 0 in all other states.
- Accept: on a rising edge with valido && pronto, latch op, rd, rs and rt, then go to LEITURA. valido is ignored while pronto = 0; the instruction is not queued.
- LEITURA, 1 cycle:
  - At the edge leaving this state, register Entrada1 <= reg[rs], Entrada2 <= reg[rt] and ALUOp <= op. All three update on the same edge.
  - Go to EXECUCAO.
- EXECUCAO, 1 cycle:
  - The ULA is combinational.
  - At the edge leaving this state, sample Resultado into a result register and Zero into a zero register.
  - Go to ESCRITA.
- ESCRITA, 1 cycle:
  - concluido = 1 during this cycle.
  - At the edge leaving this state: reg[rd] <= result register, resultado_out <= result register, flag_zero <= zero register.
  - Go to OCIOSO.
- Latency: acceptance edge to concluido high = 3 cycles. Back-to-back throughput is 1 instruction per 4 cycles.
- Operand hold: Entrada1, Entrada2 and ALUOp hold their last values outside LEITURA. They are not returned to 0.
- op encoding, passed to ALUOp unchanged:
  - 00: add.
  - 01: two's-complement negate of rs; rt is ignored by the ULA but Entrada2 is still driven with reg[rt].
  - 10: rs - rt.
  - 11: sign mask of rs - rt (0xFF or 0x00).
- Arithmetic: all results are truncated to 8 bits, with no carry or overflow output.
- Load port:
  - carga_en is honoured only in OCIOSO, where reg[carga_end] <= carga_dado at the edge.
  - In any other state it is ignored, with no error.
- Load and accept in the same OCIOSO edge: both take effect. The load is visible to this instruction's operand read in LEITURA.
- rd == rs or rd == rt: operands are read in LEITURA before the ESCRITA write, so the old value is used.
- Reset mid-operation (any state): the instruction is abandoned, with no writeback and no concluido. All state is as after reset on the next cycle.
- An illegal state encoding returns to OCIOSO.

Test Plan:
- Reset, then load r1 = 0x05 and r2 = 0x03, then issue op=00, rd=3, rs=1, rt=2 -> Entrada1 = 0x05, Entrada2 = 0x03, ALUOp = 00 after LEITURA; concluido 3 cycles after accept; r3 = 0x08; flag_zero = 0.
- r1 = 0x03, r2 = 0x03, op=10, rd=0 -> resultado_out = 0x00, flag_zero = 1. Then op=01, rs=1 -> 0xFD, flag_zero = 0.
- r1 = 0x02, r2 = 0x07, op=11 -> 0xFF. Then swap operands -> 0x00 with flag_zero = 1.
- Hold valido high continuously with two instructions -> the second is accepted only when pronto returns, 4 cycles after the first acceptance. carga_en pulsed mid-operation leaves the bank unchanged.
- op=00, rd=1, rs=1, rt=1 with r1 = 0x80 -> r1 = 0x00 (wrap), flag_zero = 1.
- Assert reset in EXECUCAO -> no concluido pulse, the destination register reads 0, and pronto = 1 one cycle after reset is released.
